// File: rtl/riscv_dmem_lsu_if.sv
// Core-side request/response channel of the data-memory load/store unit.
// The core is the master (drives requests); the LSU is the slave.
interface riscv_dmem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/riscv_dmem_lsu.sv
// Load/store unit in front of a whole-word synchronous RAM: alignment/range
// checks, load extension, and read-modify-write for byte/half stores.
module riscv_dmem_lsu #(
    parameter int AW = 7
) (
    input  logic            clk,
    input  logic            rst,
    riscv_dmem_lsu_if.slave core,
    output logic            mem_en,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [31:0]     mem_wdata,
    input  logic [31:0]     mem_rdata
);
    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

    state_t      state, next;
    logic [1:0]  size_r;
    logic        uns_r;
    logic [AW+1:0] addr_r;
    logic [31:0] wdata_r;
    logic [31:0] merged_r;
    logic [31:0] rdata_r;
    logic        err_r;

    logic        accept;
    logic        req_err;
    logic [4:0]  sh;
    logic [15:0] lane;
    logic [31:0] mask;
    logic [31:0] merged;
    logic [31:0] ld;

    assign core.req_ready  = (state == IDLE) && !rst;
    assign core.resp_valid = (state == RESP) && !rst;
    assign core.resp_rdata = rdata_r;
    assign core.resp_err   = err_r;
    assign mem_addr        = addr_r[AW+1:2];
    assign mem_wdata       = (size_r == 2'd2) ? wdata_r : merged_r;

    always_comb begin
        accept  = core.req_valid && core.req_ready;
        req_err = (core.req_size == 2'd3)
               || (core.req_size == 2'd1 && core.req_addr[0])
               || (core.req_size == 2'd2 && core.req_addr[1:0] != 2'b00)
               || (core.req_addr[31:AW+2] != '0);

        // Shifting the RAM word down by the byte offset puts the addressed
        // byte or half at bit 0; halves are aligned so the same shift works.
        sh     = {addr_r[1:0], 3'b000};
        lane   = 16'(mem_rdata >> sh);
        mask   = (size_r == 2'd0) ? (32'h0000_00FF << sh) : (32'h0000_FFFF << sh);
        merged = (mem_rdata & ~mask) | ((wdata_r << sh) & mask);

        case (size_r)
            2'd0:    ld = uns_r ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
            2'd1:    ld = uns_r ? {16'h0, lane} : {{16{lane[15]}}, lane};
            default: ld = mem_rdata;
        endcase

        next   = state;
        mem_en = 1'b0;
        mem_we = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (req_err)                    next = RESP;
                else if (!core.req_we)          next = RD;
                else if (core.req_size == 2'd2) next = WR;
                else                            next = RMW_RD;
            end
            RD:     begin mem_en = 1'b1; next = RESP; end
            RMW_RD: begin mem_en = 1'b1; next = WR; end
            WR:     begin mem_en = 1'b1; mem_we = 1'b1; next = RESP; end
            RESP:   next = IDLE;
            default: next = IDLE;
        endcase
        // A write must never reach the RAM while reset is asserted.
        if (rst) begin
            mem_en = 1'b0;
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            size_r   <= '0;
            uns_r    <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            merged_r <= '0;
            rdata_r  <= '0;
            err_r    <= 1'b0;
        end else begin
            state <= next;
            if (accept) begin
                size_r  <= core.req_size;
                uns_r   <= core.req_unsigned;
                addr_r  <= core.req_addr[AW+1:0];
                wdata_r <= core.req_wdata;
                if (req_err) begin
                    rdata_r <= '0;
                    err_r   <= 1'b1;
                end
            end
            case (state)
                RD:     begin rdata_r <= ld; err_r <= 1'b0; end
                RMW_RD: merged_r <= merged;
                WR:     begin rdata_r <= '0; err_r <= 1'b0; end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_dmem_lsu.sv
// Directed bench for riscv_dmem_lsu with a behavioural whole-word RAM.
module tb_riscv_dmem_lsu;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en, mem_we;
    logic [6:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] ram [0:127];
    int total = 0;
    int bad   = 0;

    riscv_dmem_lsu_if bus();

    riscv_dmem_lsu #(.AW(7)) dut (
        .clk(clk), .rst(rst), .core(bus),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int en_cnt, output int we_cnt, output logic [6:0] we_addr);
        lat = 0; rdata = '0; err = 1'b0; en_cnt = 0; we_cnt = 0; we_addr = '0;
        for (int i = 0; i < 5 && !bus.req_ready; i++) begin @(posedge clk); #1; end
        bus.req_we = we; bus.req_size = size; bus.req_unsigned = uns;
        bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (mem_en) en_cnt++;
            if (mem_we) begin we_cnt++; we_addr = mem_addr; end
            if (bus.resp_valid) begin lat = c; rdata = bus.resp_rdata; err = bus.resp_err; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        @(posedge clk); @(posedge clk); #1;
        total++;
        if ({bus.req_ready, bus.resp_valid, bus.resp_err, mem_en, mem_we} !== 5'b0 ||
            bus.resp_rdata !== 32'h0 || mem_addr !== 7'h0 || mem_wdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b rv=%b err=%b en=%b we=%b rd=%h ad=%h wd=%h want all 0",
                     bus.req_ready, bus.resp_valid, bus.resp_err, mem_en, mem_we,
                     bus.resp_rdata, mem_addr, mem_wdata);
        end
        rst = 1'b0; #1;
        total++;
        if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", bus.req_ready); end
    endtask

    task automatic test_word();
        int lat, en, wc; logic [31:0] rd; logic er; logic [6:0] wa;
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, en, wc, wa);
        total++;
        if (lat !== 2 || er !== 1'b0) begin bad++; $display("FAIL st_word_lat got lat=%0d err=%b want 2/0", lat, er); end
        total++;
        if (wc !== 1 || wa !== 7'd4) begin bad++; $display("FAIL st_word_we got cnt=%0d addr=%0d want 1/4", wc, wa); end
        total++;
        if (ram[4] !== 32'hDEADBEEF) begin bad++; $display("FAIL st_word_mem got %h want deadbeef", ram[4]); end
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, er, en, wc, wa);
        total++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || wc !== 0) begin
            bad++; $display("FAIL ld_word got lat=%0d data=%h we=%0d want 2/deadbeef/0", lat, rd, wc);
        end
    endtask

    task automatic test_subword();
        int lat, en, wc; logic [31:0] rd; logic er; logic [6:0] wa;
        ram[4] = 32'h11223344;
        do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000005A, lat, rd, er, en, wc, wa);
        total++;
        if (lat !== 3 || en !== 2 || wc !== 1) begin
            bad++; $display("FAIL st_byte_seq got lat=%0d en=%0d we=%0d want 3/2/1", lat, en, wc);
        end
        total++;
        if (ram[4] !== 32'h5A223344) begin bad++; $display("FAIL st_byte_mem got %h want 5a223344", ram[4]); end
        do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, lat, rd, er, en, wc, wa);
        total++;
        if (rd !== 32'h0000005A) begin bad++; $display("FAIL ld_sbyte13 got %h want 0000005a", rd); end
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, lat, rd, er, en, wc, wa);
        total++;
        if (rd !== 32'h00005A22) begin bad++; $display("FAIL ld_shalf12 got %h want 00005a22", rd); end
        do_req(1'b1, 2'd0, 1'b0, 32'h10, 32'hFFFFFF80, lat, rd, er, en, wc, wa);
        total++;
        if (ram[4] !== 32'h5A223380) begin bad++; $display("FAIL st_byte10_mem got %h want 5a223380", ram[4]); end
        do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0, lat, rd, er, en, wc, wa);
        total++;
        if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL ld_sbyte10 got %h want ffffff80", rd); end
        do_req(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, lat, rd, er, en, wc, wa);
        total++;
        if (rd !== 32'h00000080) begin bad++; $display("FAIL ld_ubyte10 got %h want 00000080", rd); end
        do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234BEEF, lat, rd, er, en, wc, wa);
        total++;
        if (lat !== 3 || ram[4] !== 32'hBEEF3380) begin
            bad++; $display("FAIL st_half12 got lat=%0d mem=%h want 3/beef3380", lat, ram[4]);
        end
        do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, lat, rd, er, en, wc, wa);
        total++;
        if (rd !== 32'hFFFFBEEF) begin bad++; $display("FAIL ld_shalf_neg got %h want ffffbeef", rd); end
        do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, lat, rd, er, en, wc, wa);
        total++;
        if (rd !== 32'h0000BEEF) begin bad++; $display("FAIL ld_uhalf got %h want 0000beef", rd); end
        do_req(1'b1, 2'd2, 1'b0, 32'h1FC, 32'h12345678, lat, rd, er, en, wc, wa);
        total++;
        if (lat !== 2 || er !== 1'b0 || wa !== 7'h7F || ram[127] !== 32'h12345678) begin
            bad++; $display("FAIL st_top_word got lat=%0d err=%b addr=%h mem=%h want 2/0/7f/12345678",
                            lat, er, wa, ram[127]);
        end
    endtask

    task automatic test_errors();
        int lat, en, wc; logic [31:0] rd; logic er; logic [6:0] wa;
        logic        we_t [5]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0]  sz_t [5]   = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0};
        logic [31:0] ad_t [5]   = '{32'h11, 32'h06, 32'h10, 32'h200, 32'h8000_0010};
        // Leave a non-zero load result behind so a stale resp_rdata shows up.
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, er, en, wc, wa);
        for (int i = 0; i < 5; i++) begin
            do_req(we_t[i], sz_t[i], 1'b0, ad_t[i], 32'hFFFF_FFFF, lat, rd, er, en, wc, wa);
            total++;
            if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || en !== 0) begin
                bad++; $display("FAIL err_vec%0d got lat=%0d err=%b data=%h en=%0d want 1/1/0/0",
                                i, lat, er, rd, en);
            end
        end
        total++;
        if (ram[1] !== 32'h0) begin bad++; $display("FAIL err_no_write got %h want 0", ram[1]); end
    endtask

    task automatic test_reset_mid();
        int resp = 0;
        ram[8] = 32'hAABBCCDD;
        for (int i = 0; i < 5 && !bus.req_ready; i++) begin @(posedge clk); #1; end
        bus.req_we = 1'b1; bus.req_size = 2'd0; bus.req_addr = 32'h20;
        bus.req_wdata = 32'h11; bus.req_valid = 1'b1;
        @(posedge clk); #1; bus.req_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (mem_we !== 1'b1) begin bad++; $display("FAIL rmw_in_wr got we=%b want 1", mem_we); end
        rst = 1'b1; #1;
        total++;
        if (mem_we !== 1'b0 || mem_en !== 1'b0) begin
            bad++; $display("FAIL rst_gate got en=%b we=%b want 0/0", mem_en, mem_we);
        end
        @(posedge clk); #1; rst = 1'b0; #1;
        total++;
        if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", bus.req_ready); end
        // Abort a second store while it is still reading.
        bus.req_valid = 1'b1;
        @(posedge clk); #1; bus.req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (bus.resp_valid) resp++;
            @(posedge clk); #1;
        end
        total++;
        if (ram[8] !== 32'hAABBCCDD || resp !== 0) begin
            bad++; $display("FAIL rst_abort got mem=%h resp=%0d want aabbccdd/0", ram[8], resp);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ad_t [4] = '{32'h30, 32'h34, 32'h38, 32'h3C};
        logic [31:0] dv_t [4] = '{32'h01020304, 32'hCAFEF00D, 32'h0BADC0DE, 32'h76543210};
        int acc [4]; int rsp [4]; logic [31:0] rdv [4];
        int na = 0, nr = 0, cyc = 0;
        logic take;
        for (int i = 0; i < 4; i++) ram[12+i] = dv_t[i];
        bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_unsigned = 1'b0;
        bus.req_addr = ad_t[0]; bus.req_valid = 1'b1;
        while (nr < 4 && cyc < 40) begin
            take = bus.req_valid && bus.req_ready;
            if (bus.resp_valid) begin rsp[nr] = cyc; rdv[nr] = bus.resp_rdata; nr++; end
            @(posedge clk); #1; cyc++;
            if (take) begin
                acc[na] = cyc; na++;
                if (na < 4) bus.req_addr = ad_t[na]; else bus.req_valid = 1'b0;
            end
        end
        bus.req_valid = 1'b0;
        total++;
        if (na !== 4 || nr !== 4) begin bad++; $display("FAIL b2b_count got acc=%0d resp=%0d want 4/4", na, nr); end
        else begin
            for (int i = 1; i < 4; i++) begin
                total++;
                if (acc[i] - acc[i-1] !== 3 || rsp[i] - rsp[i-1] !== 3) begin
                    bad++; $display("FAIL b2b_gap%0d got acc=%0d resp=%0d want 3/3",
                                    i, acc[i] - acc[i-1], rsp[i] - rsp[i-1]);
                end
            end
            for (int i = 0; i < 4; i++) begin
                total++;
                if (rdv[i] !== dv_t[i]) begin bad++; $display("FAIL b2b_data%0d got %h want %h", i, rdv[i], dv_t[i]); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ram[i] = 32'h0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
